// File: rtl/t_stream_buffer.sv
// t_stream_buffer: T-sequence/boundary-score store that streams {t, v, v-alpha, f} to PE0 and takes back V/F.
// Optional TBUF_SAT_EN clamps o_v_a to zero when the signed sum is negative.
module t_stream_buffer #(
  parameter int T_MAX_LEN = 1024,
  parameter int ADDR_W    = 10,
  parameter int VEF_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [ADDR_W:0]    i_t_len,
  input  logic               i_load_valid,
  input  logic [1:0]         i_load_t,
  output logic               o_load_ready,
  input  logic               i_pass_start,
  input  logic               i_last_pass,
  input  logic [VEF_W-1:0]   i_minusAlpha,
  input  logic               i_lock,
  output logic [1:0]         o_t,
  output logic [VEF_W-1:0]   o_v,
  output logic [VEF_W-1:0]   o_v_a,
  output logic [VEF_W-1:0]   o_f,
  output logic               o_t_valid,
  output logic               o_t_newline,
  output logic               o_enable_0,
  input  logic [1:0]         i_ret_t,
  input  logic [VEF_W-1:0]   i_ret_v,
  input  logic [VEF_W-1:0]   i_ret_f,
  input  logic               i_ret_valid,
  output logic               o_busy,
  output logic               o_pass_done
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, STREAM, WB} state_t;
  localparam logic [ADDR_W:0] LMAX = T_MAX_LEN[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
  state_t             state_q;
  logic [ADDR_W:0]    len_q, wr_q, rd_q, wb_q, lm1;
  logic               last_q, s1_vld_q, s1_nl_q;
  logic               issue, ret_ok, load_we;
  logic [1:0]         mem_t [T_MAX_LEN];
  logic [VEF_W-1:0]   mem_v [T_MAX_LEN];
  logic [VEF_W-1:0]   mem_f [T_MAX_LEN];
  logic [1:0]         s1_t_q;
  logic [VEF_W-1:0]   s1_v_q, s1_f_q, va_d;

  assign lm1          = len_q - ONE;
  assign issue        = state_q == STREAM && !i_lock;
  assign load_we      = state_q == LOAD && i_load_valid;
  assign ret_ok       = (state_q == STREAM || state_q == WB) && !last_q && i_ret_valid && wb_q != len_q;
  assign o_busy       = state_q != IDLE;
  assign o_load_ready = state_q == LOAD;

`ifdef TBUF_SAT_EN
  logic [VEF_W:0] sum;
  assign sum  = {s1_v_q[VEF_W-1], s1_v_q} + {i_minusAlpha[VEF_W-1], i_minusAlpha};
  assign va_d = sum[VEF_W] ? '0 : sum[VEF_W-1:0];
`else
  assign va_d = s1_v_q + i_minusAlpha;
`endif

  // Boundary RAM plus the read stage; nonblocking writes give read-first on address collisions.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_t[wr_q[ADDR_W-1:0]] <= i_load_t;
      mem_v[wr_q[ADDR_W-1:0]] <= '0;
      mem_f[wr_q[ADDR_W-1:0]] <= '0;
    end
    if (ret_ok) begin
      assert (i_ret_t == mem_t[wb_q[ADDR_W-1:0]]);
      mem_v[wb_q[ADDR_W-1:0]] <= i_ret_v;
      mem_f[wb_q[ADDR_W-1:0]] <= i_ret_f;
    end
    if (issue) begin
      s1_t_q <= mem_t[rd_q[ADDR_W-1:0]];
      s1_v_q <= mem_v[rd_q[ADDR_W-1:0]];
      s1_f_q <= mem_f[rd_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      wb_q        <= '0;
      last_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_nl_q     <= 1'b0;
      o_t         <= '0;
      o_v         <= '0;
      o_v_a       <= '0;
      o_f         <= '0;
      o_t_valid   <= 1'b0;
      o_t_newline <= 1'b0;
      o_enable_0  <= 1'b0;
      o_pass_done <= 1'b0;
    end else begin
      o_pass_done <= 1'b0;
      if (!i_lock) begin
        s1_vld_q    <= issue;
        s1_nl_q     <= issue && rd_q == lm1;
        o_t_valid   <= s1_vld_q;
        o_enable_0  <= s1_vld_q;
        o_t_newline <= s1_vld_q && s1_nl_q;
        o_t         <= s1_vld_q ? s1_t_q : '0;
        o_v         <= s1_vld_q ? s1_v_q : '0;
        o_v_a       <= s1_vld_q ? va_d : '0;
        o_f         <= s1_vld_q ? s1_f_q : '0;
      end
      if (ret_ok) wb_q <= wb_q + ONE;
      case (state_q)
        IDLE: if (i_start) begin
          state_q <= LOAD;
          len_q   <= (i_t_len == '0 || i_t_len > LMAX) ? LMAX : i_t_len;
          wr_q    <= '0;
        end
        LOAD: if (i_load_valid) begin
          wr_q <= wr_q + ONE;
          if (wr_q == lm1) state_q <= READY;
        end
        READY: if (i_pass_start) begin
          state_q <= STREAM;
          rd_q    <= '0;
          wb_q    <= '0;
          last_q  <= i_last_pass;
        end
        STREAM: if (issue) begin
          rd_q <= rd_q + ONE;
          if (rd_q == lm1) state_q <= WB;
        end
        WB: if (last_q ? !(s1_vld_q || o_t_valid) : wb_q == len_q) begin
          state_q     <= last_q ? IDLE : READY;
          o_pass_done <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
